// File: rtl/hshrink_pkg.sv
// Shared constants and helpers for the horizontal sprite-shrink path.
// Latency: n/a (elaboration-time constants and pure functions).
// Backpressure: n/a.
package hshrink_pkg;

    localparam int DEF_SHRINK_W = 4;
    localparam int DEF_LANES    = 2;
    localparam int MAX_SHRINK_W = 6;
    localparam int MAX_T        = 1 << MAX_SHRINK_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Tile width in pixels for a given shrink-code width.
    function automatic int tile_w(input int shrink_w);
        return 1 << shrink_w;
    endfunction

    // Number of beats needed to stream one tile row.
    function automatic int beat_cnt(input int shrink_w, input int lanes);
        return (1 << shrink_w) / lanes;
    endfunction

    // Beat counter width; at least one bit even for a single-beat row.
    function automatic int beat_idx_w(input int shrink_w, input int lanes);
        int beats;
        beats = (1 << shrink_w) / lanes;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Keep rule for pixel p under shrink code s: with K = s+1, pixel p is kept
    // when the scaled position crosses an integer boundary. Products stay
    // below 2^(2*shrink_w+1), so 32-bit int arithmetic cannot overflow.
    function automatic logic keep_rule(input int shrink_w, input int s, input int p);
        int k;
        k = s + 1;
        return (((p + 1) * k) >> shrink_w) != ((p * k) >> shrink_w);
    endfunction

    // Number of set bits in a (zero-extended) lane vector.
    function automatic int popcount(input logic [MAX_T-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_T; i++) begin
            cnt += int'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hshrink_mask.sv
// Builds the T-bit pixel keep mask from a shrink code, optionally bit-reversed.
// Latency: purely combinational.
// Backpressure: none; output follows inputs directly.
module hshrink_mask
    import hshrink_pkg::*;
#(
    parameter int SHRINK_W = DEF_SHRINK_W
) (
    input  logic [SHRINK_W-1:0]        shrink_i,
    input  logic                       flip_i,
    output logic [(1<<SHRINK_W)-1:0]   mask_o
);

    localparam int T = tile_w(SHRINK_W);

    logic [T-1:0] raw_mask;

    // Evaluate the keep rule for every pixel position of the tile row.
    always_comb begin
        raw_mask = '0;
        for (int p = 0; p < T; p++) begin
            raw_mask[p] = keep_rule(SHRINK_W, int'(shrink_i), p);
        end
    end

    // Horizontal flip is a plain bit reversal of the row.
    always_comb begin
        mask_o = '0;
        for (int i = 0; i < T; i++) begin
            mask_o[i] = flip_i ? raw_mask[T-1-i] : raw_mask[i];
        end
    end

endmodule

// File: rtl/hshrink_seq.sv
// Streams a shrink keep-mask LANES pixels per beat with a per-beat kept count.
// Latency: beat 0 registered one cycle after LOAD; back-to-back rows have no bubble.
// Backpressure: ADV low holds every output; LOAD always overrides ADV.
module hshrink_seq
    import hshrink_pkg::*;
#(
    parameter int SHRINK_W = DEF_SHRINK_W,
    parameter int LANES    = DEF_LANES
) (
    input  logic                         CK,
    input  logic                         nRESET,
    input  logic                         LOAD,
    input  logic [SHRINK_W-1:0]          SHRINK,
    input  logic                         FLIP,
    input  logic                         ADV,
    output logic [LANES-1:0]             PIX_EN,
    output logic                         VALID,
    output logic                         LAST,
    output logic [$clog2(LANES+1)-1:0]   XINC,
    output logic                         BUSY
);

    localparam int T     = tile_w(SHRINK_W);
    localparam int BEATS = beat_cnt(SHRINK_W, LANES);
    localparam int BW    = beat_idx_w(SHRINK_W, LANES);
    localparam int XW    = $clog2(LANES + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    seq_state_e                     state_q, state_d;
    logic [BW-1:0]                  beat_q, beat_d;
    logic [T-1:0]                   mask_q, mask_d, load_mask;
    logic [BEATS-1:0][LANES-1:0]    mask_beats;
    logic [LANES-1:0]               pix_en_q, pix_en_d;
    logic                           valid_q, valid_d;
    logic                           last_q, last_d;
    logic [XW-1:0]                  xinc_q, xinc_d;

    hshrink_mask #(
        .SHRINK_W (SHRINK_W)
    ) u_mask (
        .shrink_i (SHRINK),
        .flip_i   (FLIP),
        .mask_o   (load_mask)
    );

    // Sequencer: LOAD restarts a row from any state, ADV steps through beats.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        mask_d  = mask_q;
        if (LOAD) begin
            state_d = ST_RUN;
            beat_d  = '0;
            mask_d  = load_mask;
        end else if (state_q == ST_RUN && ADV) begin
            if (beat_q == LAST_BEAT) begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    // View the row mask as one LANES-wide slice per beat.
    assign mask_beats = mask_d;

    // Precompute the next beat's outputs so they can be registered.
    always_comb begin
        valid_d  = (state_d == ST_RUN);
        pix_en_d = '0;
        last_d   = 1'b0;
        if (valid_d) begin
            pix_en_d = mask_beats[beat_d];
            last_d   = (beat_d == LAST_BEAT);
        end
        xinc_d = XW'(popcount(MAX_T'(pix_en_d)));
    end

    // Sequencer state, beat index and captured mask.
    always_ff @(posedge CK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            mask_q  <= mask_d;
        end
    end

    // Registered beat outputs.
    always_ff @(posedge CK or negedge nRESET) begin
        if (!nRESET) begin
            pix_en_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            xinc_q   <= '0;
        end else begin
            pix_en_q <= pix_en_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            xinc_q   <= xinc_d;
        end
    end

    assign PIX_EN = pix_en_q;
    assign VALID  = valid_q;
    assign LAST   = last_q;
    assign XINC   = xinc_q;
    assign BUSY   = valid_q;

endmodule

// File: doc/hshrink_seq.md
Name: hshrink_seq

Overview:
- Parametrised horizontal sprite-shrink pixel-enable sequencer for the sprite line renderer.
- On LOAD it captures a shrink code and builds a keep-mask across one tile row of 2^SHRINK_W pixels.
- It then streams the mask LANES pixels per beat, with ADV as flow control, an optional horizontal flip, and a per-beat kept-pixel count that drives the line-buffer X address increment.
- Successor to the fixed 16-pixel, 2-lane shrink shifter: width, lane count and flip are generalised; stall, abort/reload and kept-pixel counting are new.

Parameters:
- SHRINK_W, 4, shrink code width; tile width T = 2^SHRINK_W pixels (legal 2..6).
- LANES, 2, pixels emitted per beat; power of two, 1 <= LANES <= T.

Ports:
- CK  in  1  clock, rising edge.
- nRESET  in  1  asynchronous active-low reset.
- LOAD  in  1  start a new tile row; captures SHRINK and FLIP.
- SHRINK  in  SHRINK_W  shrink code S; S+1 pixels of T are kept.
- FLIP  in  1  horizontal flip for the loaded row.
- ADV  in  1  consume the current beat.
- PIX_EN  out  LANES  per-lane keep flags for the current beat.
- VALID  out  1  PIX_EN/XINC hold a live beat.
- LAST  out  1  current beat is the final beat of the row.
- XINC  out  clog2(LANES+1)  popcount of PIX_EN.
- BUSY  out  1  equals VALID (alias for the sequencer FSM).

Behaviour:
- Keep rule: K = S+1. Pixel p (0..T-1) is kept iff ((p+1)*K >> SHRINK_W) != ((p*K) >> SHRINK_W).
  - Exactly K pixels are kept, evenly spread.
  - S = all-ones keeps every pixel.
  - S = 0 keeps only p = T-1.
  - Arithmetic width is SHRINK_W*2+1 bits; no overflow is permitted.
- Beats: BEATS = T/LANES, beat index b = 0..BEATS-1.
  - Lane l of beat b maps to p = b*LANES + l.
  - When FLIP is captured as 1, p = T-1-(b*LANES+l).
- Reset (nRESET low, asynchronous):
  - PIX_EN = 0, VALID = 0, LAST = 0, XINC = 0, BUSY = 0.
  - Beat counter = 0, captured mask = 0.
- FSM has two states, IDLE and RUN.
  - IDLE: LOAD=1 at a CK edge computes and registers the mask, sets b = 0 and moves to RUN. Beat 0 is visible on the outputs the cycle after that edge (1-cycle load latency).
  - RUN with ADV=1 and not LAST: b increments at the edge.
  - RUN with ADV=1 and LAST, LOAD=0: return to IDLE; VALID drops next cycle.
  - RUN with ADV=0: all outputs hold unchanged (stall of any length).
- Simultaneous events:
  - LOAD=1 together with ADV=1 on the LAST beat: seamless back-to-back. The new row's beat 0 appears next cycle with no bubble.
  - LOAD=1 in RUN on a non-last beat: abort the current row and reload. ADV in that cycle is ignored and the remaining old beats are discarded.
  - LOAD always wins over ADV.
- SHRINK and FLIP are sampled only at the LOAD edge; later changes have no effect until the next LOAD.
- Outputs are registered.
  - XINC = popcount(PIX_EN) for the same beat.
  - LAST = VALID && (b == BEATS-1).
  - PIX_EN and XINC are 0 whenever VALID = 0.
- Sum of XINC over a complete row = S+1.
- Reset asserted mid-row returns to IDLE immediately; no partial row resumes.

Decomposition:
- Shared package hshrink_pkg holds:
  - tile-width and beat-count constants derived from SHRINK_W/LANES;
  - the keep-rule function (mask from S);
  - the popcount function.
- Sub-module hshrink_mask is combinational: SHRINK and FLIP in, T-bit keep mask out, with flip applied by bit-reversal. It is reusable by the vertical-shrink path.
- hshrink_seq holds the mask register, beat counter, FSM and output registers.

Test Plan:
- Defaults, S=4'h7, FLIP=0, ADV held 1 -> 8 beats, each PIX_EN=2'b10, XINC=1; LAST on beat 7; VALID drops the cycle after; sum XINC=8.
- Defaults, S=4'h0 then S=4'hF, FLIP=0 -> S=0: only beat 7 has PIX_EN=2'b10, sum=1. S=F: every beat PIX_EN=2'b11, sum=16.
- S=4'h0, FLIP=1 -> beat 0 PIX_EN=2'b01, all other beats 0.
- Stall: ADV low for 5 cycles on beat 3 -> outputs frozen; row resumes at beat 3; total 8 beats delivered.
- Back-to-back and abort:
  - LOAD+ADV on LAST -> no VALID gap; new row's beat 0 appears next cycle.
  - LOAD on beat 2 -> next cycle shows the new row's beat 0; old beats 3..7 never appear.
- Parameter sweep SHRINK_W=5, LANES=4, random S and FLIP -> 8 beats per row; sum XINC=S+1; mask matches the reference model of the keep rule. Also: nRESET pulsed mid-row -> all outputs 0 asynchronously, IDLE after release.
